// File: rtl/noc_event_fifo_if.sv
// Handshake bundle for noc_event_fifo: FIFO write/read port plus the edge-detector signals.
// The master side drives requests and the monitored level; the slave side is the FIFO block.
interface noc_event_fifo_if #(
  parameter int unsigned WIDTH = 37
);
  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             sig;
  logic             rising_or_falling;
  logic             edge_detected;

  modport master (
    output data_in, wr_en, rd_en, sig, rising_or_falling,
    input  data_out, empty, full, edge_detected
  );

  modport slave (
    input  data_in, wr_en, rd_en, sig, rising_or_falling,
    output data_out, empty, full, edge_detected
  );
endinterface

// File: rtl/noc_event_fifo.sv
// Response-descriptor FIFO with registered read data, plus a one-flop edge detector that
// turns level changes on a handshake signal into single-cycle pulses.
module noc_event_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  noc_event_fifo_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             sig_q;
  logic             empty;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  // A write while full is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FullCount);
    rd_ok = bus.rd_en & ~empty;
    wr_ok = bus.wr_en & (~full | rd_ok);
  end

  // Storage is left unreset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      sig_q      <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (rd_ok) begin
        rptr_q     <= rptr_q + 1'b1;
        data_out_q <= mem[rptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      sig_q <= bus.sig;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.edge_detected = bus.rising_or_falling ? (bus.sig & ~sig_q) : (~bus.sig & sig_q);
endmodule

// File: tb/tb_noc_event_fifo.sv
// Directed bench for noc_event_fifo: a queue scoreboard predicts read data and status,
// and hand-derived expectations cover the edge detector and asynchronous reset.
module tb_noc_event_fifo;
  localparam int unsigned W = 37;
  localparam int unsigned D = 16;

  logic clk;
  logic rst;

  noc_event_fifo_if #(.WIDTH(W)) bus ();

  noc_event_fifo #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  logic [W-1:0]     sb[$];
  logic [W-1:0]     exp_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of FIFO traffic; the scoreboard decides acceptance from its own occupancy.
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit rok;
    bit wok;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    rok = r && (sb.size() != 0);
    wok = w && ((sb.size() < D) || rok);
    @(posedge clk);
    #1;
    if (rok) exp_dout = sb.pop_front();
    if (wok) sb.push_back(d);
    chk({tag, ".data_out"}, 64'(bus.data_out), 64'(exp_dout));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(sb.size() == 0));
    chk({tag, ".full"}, 64'(bus.full), 64'(sb.size() == D));
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Apply a level, check the combinational pulse mid-cycle, then clock it into sig_q.
  task automatic edge_step(input logic s, input logic mode, input logic exp, input string tag);
    bus.sig = s;
    bus.rising_or_falling = mode;
    #2;
    chk(tag, 64'(bus.edge_detected), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.data_in           = '0;
    bus.wr_en             = 1'b0;
    bus.rd_en             = 1'b0;
    bus.sig               = 1'b0;
    bus.rising_or_falling = 1'b1;
    exp_dout              = '0;

    #12;
    chk("rst.empty", 64'(bus.empty), 64'd1);
    chk("rst.full", 64'(bus.full), 64'd0);
    chk("rst.data_out", 64'(bus.data_out), 64'd0);
    chk("rst.edge", 64'(bus.edge_detected), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, '0, "rd_empty");

    // Basic ordering
    cycle(1'b1, 1'b0, 37'h1_0000_0001, "wr0");
    cycle(1'b1, 1'b0, 37'h0_ABCD_1234, "wr1");
    cycle(1'b1, 1'b0, 37'h1F_FFFF_FFFF, "wr2");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, $sformatf("rd_basic%0d", i));

    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, W'(i), $sformatf("fill%0d", i));
    cycle(1'b1, 1'b0, W'(99), "overflow");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
      chk($sformatf("drain_val%0d", i), 64'(bus.data_out), 64'(i));
    end

    // Full with simultaneous read/write: both happen, stays full
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, W'(500 + i), $sformatf("refill%0d", i));
    cycle(1'b1, 1'b1, W'(600), "full_rw");
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, $sformatf("drain2_%0d", i));

    // Half full, then sustained concurrent traffic across pointer wrap
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(1000 + i), $sformatf("half%0d", i));
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, W'(1008 + i), $sformatf("wrap%0d", i));
      chk($sformatf("wrap_seq%0d", i), 64'(bus.data_out), 64'(1000 + i));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, $sformatf("wdrain%0d", i));

    // Simultaneous read/write while empty: only the write happens
    cycle(1'b1, 1'b1, W'(77), "empty_rw");
    chk("empty_rw.hold", 64'(bus.data_out), 64'(1047));
    cycle(1'b0, 1'b1, '0, "empty_rw_rd");

    // Edge detector, rising then falling mode
    edge_step(1'b0, 1'b1, 1'b0, "rise.s0");
    edge_step(1'b1, 1'b1, 1'b1, "rise.s1");
    edge_step(1'b1, 1'b1, 1'b0, "rise.s1b");
    edge_step(1'b0, 1'b1, 1'b0, "rise.s0b");
    edge_step(1'b0, 1'b0, 1'b0, "fall.s0");
    edge_step(1'b1, 1'b0, 1'b0, "fall.s1");
    edge_step(1'b1, 1'b0, 1'b0, "fall.s1b");
    edge_step(1'b0, 1'b0, 1'b1, "fall.s0b");
    // Mode switch acts immediately while sig_q still lags sig
    bus.sig = 1'b1;
    bus.rising_or_falling = 1'b1;
    #1 chk("mode.rise", 64'(bus.edge_detected), 64'd1);
    bus.rising_or_falling = 1'b0;
    #1 chk("mode.fall", 64'(bus.edge_detected), 64'd0);
    @(posedge clk);
    #1;

    // Async reset with 5 entries queued and non-zero data_out
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(300 + i), $sformatf("pre%0d", i));
    cycle(1'b0, 1'b1, '0, "pre_rd");
    bus.rising_or_falling = 1'b1;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_dout = '0;
    chk("arst.empty", 64'(bus.empty), 64'd1);
    chk("arst.data_out", 64'(bus.data_out), 64'd0);
    chk("arst.edge_in_rst", 64'(bus.edge_detected), 64'd1);
    #1 rst = 1'b0;
    #1 chk("arst.edge_release", 64'(bus.edge_detected), 64'd1);
    @(posedge clk);
    #1 chk("arst.edge_after", 64'(bus.edge_detected), 64'd0);
    cycle(1'b1, 1'b0, W'(4242), "post_wr");
    cycle(1'b0, 1'b1, '0, "post_rd");
    chk("post_rd.val", 64'(bus.data_out), 64'd4242);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
